// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, types and frame-decoding helpers for the
// 74HC595-chain receiver.
//   CHAIN_BITS      bits per row frame
//   *_MSB           bit position of each field's column-0 / row-0 bit in
//                   the shift register
//   rgb_row_t       one decoded row, active-high, bit c = column c
//   frame_kind_t    outcome of checking a latched frame
package matrix_pkg;

    localparam int CHAIN_BITS = 32;
    localparam int RED_MSB    = 31;
    localparam int BLUE_MSB   = 23;
    localparam int GREEN_MSB  = 15;
    localparam int ANODE_MSB  = 7;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_row_t;

    typedef enum logic [1:0] {
        FRAME_LEN_ERR,
        FRAME_ROW_ERR,
        FRAME_BLANK,
        FRAME_GOOD
    } frame_kind_t;

    // Cathode fields are active-low on the wire.
    function automatic rgb_row_t decode_colours(input logic [CHAIN_BITS-1:0] frame);
        rgb_row_t row;
        row = '0;
        for (int c = 0; c < 8; c++) begin
            row.red[c]   = ~frame[RED_MSB - c];
            row.blue[c]  = ~frame[BLUE_MSB - c];
            row.green[c] = ~frame[GREEN_MSB - c];
        end
        return row;
    endfunction

    function automatic logic [7:0] decode_anode(input logic [CHAIN_BITS-1:0] frame);
        logic [7:0] anode;
        anode = '0;
        for (int j = 0; j < 8; j++) begin
            anode[j] = frame[ANODE_MSB - j];
        end
        return anode;
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int j = 0; j < 8; j++) begin
            if (onehot[j]) idx = 3'(j);
        end
        return idx;
    endfunction

    // Checks are ordered: length first, then anode multi-hot, then blank.
    function automatic frame_kind_t classify(input logic [5:0] cnt, input logic [7:0] anode);
        frame_kind_t kind;
        if (cnt != 6'(CHAIN_BITS)) begin
            kind = FRAME_LEN_ERR;
        end else if ((anode & (anode - 8'd1)) != 8'd0) begin
            kind = FRAME_ROW_ERR;
        end else if (anode == 8'd0) begin
            kind = FRAME_BLANK;
        end else begin
            kind = FRAME_GOOD;
        end
        return kind;
    endfunction

endpackage

// File: rtl/matrix_rx_if.sv
// matrix_rx_if: serial pins of the 74HC595 chain as seen at the matrix.
//   matrix_clk    shift clock, data sampled on its rising edge
//   matrix_latch  storage-register latch, acts on its rising edge
//   matrix_mosi   serial data
// master = the driver producing the pins, slave = the receiver observing them.
interface matrix_rx_if;
    logic matrix_clk;
    logic matrix_latch;
    logic matrix_mosi;

    modport master (output matrix_clk, output matrix_latch, output matrix_mosi);
    modport slave  (input  matrix_clk, input  matrix_latch, input  matrix_mosi);
endinterface

// File: rtl/sync_edge.sv
// sync_edge: SYNC_STAGES-deep synchroniser followed by one delay flop for
// rising-edge detection.
//   clk, rst_n  system clock, async active-low reset
//   d           asynchronous input
//   level       synchronised level
//   rise        high for one cycle while level=1 and the delayed copy=0
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/matrix_rx.sv
// matrix_rx: rebuilds 32-bit row frames from the oversampled 74HC595 pins,
// checks them and keeps an 8x8 RGB framebuffer of the good rows.
//   clk, rst_n            system clock, async active-low reset
//   bus (slave)           matrix_clk / matrix_latch / matrix_mosi
//   row_valid             pulse per good row; frame_done with it on row 7
//   len_err, row_err      pulse on a bad length / multi-hot anode
//   row_idx, row_*        last good row and its colours
//   rd_row, rd_col        framebuffer read address
//   rd_pixel              {r,g,b}, one cycle after the address
module matrix_rx
    import matrix_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    matrix_rx_if.slave  bus,
    input  logic [2:0]  rd_row,
    input  logic [2:0]  rd_col,
    output logic        row_valid,
    output logic [2:0]  row_idx,
    output logic [7:0]  row_red,
    output logic [7:0]  row_green,
    output logic [7:0]  row_blue,
    output logic        frame_done,
    output logic        len_err,
    output logic        row_err,
    output logic [2:0]  rd_pixel
);

    logic clk_rise, latch_rise, mosi_lvl;
    logic clk_lvl_unused, latch_lvl_unused, mosi_rise_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .d(bus.matrix_clk),
        .level(clk_lvl_unused), .rise(clk_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk(clk), .rst_n(rst_n), .d(bus.matrix_latch),
        .level(latch_lvl_unused), .rise(latch_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(bus.matrix_mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused)
    );

    logic [CHAIN_BITS-1:0] shift_reg_q, shift_reg_d;
    logic [5:0]            shift_cnt_q, shift_cnt_d;
    // The latched frame is snapshotted and judged one cycle later, so the
    // result pulse lands SYNC_STAGES+1 edges after the latch is first sampled
    // and a coincident shift can proceed on the live shift register.
    logic [CHAIN_BITS-1:0] snap_q, snap_d;
    logic [5:0]            snap_cnt_q, snap_cnt_d;
    logic                  eval_q, eval_d;

    logic                  row_valid_q, row_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  len_err_q, len_err_d;
    logic                  row_err_q, row_err_d;
    logic [2:0]            row_idx_q, row_idx_d;
    rgb_row_t              row_rgb_q, row_rgb_d;
    logic [2:0]            fb_q [8][8];
    logic [2:0]            fb_d [8][8];
    logic [2:0]            rd_pixel_q, rd_pixel_d;

    rgb_row_t              snap_rgb;
    logic [7:0]            snap_anode;
    logic [2:0]            snap_idx;
    frame_kind_t           snap_kind;

    always_comb begin
        shift_reg_d = shift_reg_q;
        shift_cnt_d = shift_cnt_q;
        snap_d      = snap_q;
        snap_cnt_d  = snap_cnt_q;
        eval_d      = 1'b0;

        if (latch_rise) begin
            snap_d      = shift_reg_q;
            snap_cnt_d  = shift_cnt_q;
            eval_d      = 1'b1;
            shift_cnt_d = '0;
        end

        if (clk_rise) begin
            shift_reg_d = {shift_reg_q[CHAIN_BITS-2:0], mosi_lvl};
            if (latch_rise) begin
                shift_cnt_d = 6'd1;
            end else if (shift_cnt_q != 6'd63) begin
                shift_cnt_d = shift_cnt_q + 6'd1;
            end
        end
    end

    always_comb begin
        snap_rgb   = decode_colours(snap_q);
        snap_anode = decode_anode(snap_q);
        snap_idx   = onehot_to_idx(snap_anode);
        snap_kind  = classify(snap_cnt_q, snap_anode);

        row_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        len_err_d    = 1'b0;
        row_err_d    = 1'b0;
        row_idx_d    = row_idx_q;
        row_rgb_d    = row_rgb_q;
        fb_d         = fb_q;
        rd_pixel_d   = fb_q[rd_row][rd_col];

        if (eval_q) begin
            case (snap_kind)
                FRAME_LEN_ERR: len_err_d = 1'b1;
                FRAME_ROW_ERR: row_err_d = 1'b1;
                FRAME_GOOD: begin
                    row_valid_d  = 1'b1;
                    frame_done_d = (snap_idx == 3'd7);
                    row_idx_d    = snap_idx;
                    row_rgb_d    = snap_rgb;
                    for (int c = 0; c < 8; c++) begin
                        fb_d[snap_idx][c] = {snap_rgb.red[c], snap_rgb.green[c], snap_rgb.blue[c]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg_q  <= '0;
            shift_cnt_q  <= '0;
            snap_q       <= '0;
            snap_cnt_q   <= '0;
            eval_q       <= 1'b0;
            row_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
            row_err_q    <= 1'b0;
            row_idx_q    <= '0;
            row_rgb_q    <= '0;
            rd_pixel_q   <= '0;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    fb_q[r][c] <= '0;
                end
            end
        end else begin
            shift_reg_q  <= shift_reg_d;
            shift_cnt_q  <= shift_cnt_d;
            snap_q       <= snap_d;
            snap_cnt_q   <= snap_cnt_d;
            eval_q       <= eval_d;
            row_valid_q  <= row_valid_d;
            frame_done_q <= frame_done_d;
            len_err_q    <= len_err_d;
            row_err_q    <= row_err_d;
            row_idx_q    <= row_idx_d;
            row_rgb_q    <= row_rgb_d;
            rd_pixel_q   <= rd_pixel_d;
            fb_q         <= fb_d;
        end
    end

    assign row_valid  = row_valid_q;
    assign frame_done = frame_done_q;
    assign len_err    = len_err_q;
    assign row_err    = row_err_q;
    assign row_idx    = row_idx_q;
    assign row_red    = row_rgb_q.red;
    assign row_green  = row_rgb_q.green;
    assign row_blue   = row_rgb_q.blue;
    assign rd_pixel   = rd_pixel_q;

endmodule

// File: tb/tb_matrix_rx.sv
module tb_matrix_rx;

    localparam int SYNC_STAGES = 2;
    localparam int K_VALID = 0;
    localparam int K_LEN   = 1;
    localparam int K_ROW   = 2;

    typedef struct {
        int         kind;
        int         idx;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rd_row = '0;
    logic [2:0] rd_col = '0;
    logic       row_valid, frame_done, len_err, row_err;
    logic [2:0] row_idx, rd_pixel;
    logic [7:0] row_red, row_green, row_blue;

    matrix_rx_if bus();

    matrix_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rd_row(rd_row), .rd_col(rd_col),
        .row_valid(row_valid), .row_idx(row_idx),
        .row_red(row_red), .row_green(row_green), .row_blue(row_blue),
        .frame_done(frame_done), .len_err(len_err), .row_err(row_err),
        .rd_pixel(rd_pixel)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    bit   hist[$];
    logic [2:0] fb_m [8][8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: judge the bits shifted since the last latch straight from the
    // frame format (bit k of the frame is the k-th bit shifted).
    task automatic model_latch(input int at);
        exp_t e;
        int   n, ones;
        logic [7:0] an;
        n = hist.size();
        if (n > 63) n = 63;
        e.kind = K_LEN; e.idx = 0; e.r = 0; e.g = 0; e.b = 0; e.at = at;
        if (n != 32) begin
            exp_q.push_back(e);
        end else begin
            ones = 0;
            for (int j = 0; j < 8; j++) begin
                an[j] = hist[24 + j];
                if (an[j]) begin ones++; e.idx = j; end
            end
            if (ones > 1) begin
                e.kind = K_ROW;
                exp_q.push_back(e);
            end else if (ones == 1) begin
                e.kind = K_VALID;
                for (int c = 0; c < 8; c++) begin
                    e.r[c] = ~hist[c];
                    e.b[c] = ~hist[8 + c];
                    e.g[c] = ~hist[16 + c];
                end
                for (int c = 0; c < 8; c++) fb_m[e.idx][c] = {e.r[c], e.g[c], e.b[c]};
                exp_q.push_back(e);
            end
        end
        hist.delete();
    endtask

    task automatic shift_bit(input bit b);
        bus.matrix_mosi = b;
        wait_cyc($urandom_range(2, 3));
        bus.matrix_clk = 1'b1;
        hist.push_back(b);
        wait_cyc($urandom_range(2, 3));
        bus.matrix_clk = 1'b0;
    endtask

    task automatic do_latch(input bit coincident, input bit b);
        if (coincident) bus.matrix_mosi = b;
        wait_cyc(2);
        // latch is sampled at the next edge (cyc+1); pulse follows SYNC_STAGES+1 edges later
        model_latch(cyc + 1 + SYNC_STAGES + 1);
        bus.matrix_latch = 1'b1;
        if (coincident) begin
            bus.matrix_clk = 1'b1;
            hist.push_back(b);
        end
        wait_cyc($urandom_range(2, 3));
        bus.matrix_latch = 1'b0;
        if (coincident) bus.matrix_clk = 1'b0;
        wait_cyc(2);
    endtask

    function automatic logic [31:0] build(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b, input logic [7:0] an);
        logic [31:0] f;
        for (int c = 0; c < 8; c++) begin
            f[c]      = ~r[c];
            f[8 + c]  = ~b[c];
            f[16 + c] = ~g[c];
            f[24 + c] = an[c];
        end
        return f;
    endfunction

    task automatic send_bits(input logic [31:0] f, input int first, input int last);
        for (int k = first; k <= last; k++) shift_bit(f[k]);
    endtask

    task automatic read_check(input int r, input int c);
        rd_row = 3'(r);
        rd_col = 3'(c);
        wait_cyc(1);
        checks++;
        if (rd_pixel !== fb_m[r][c])
            $display("FAIL rd_pixel(%0d,%0d): got %b expected %b", r, c, rd_pixel, fb_m[r][c]);
        if (rd_pixel !== fb_m[r][c]) errors++;
    endtask

    task automatic read_all();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) read_check(r, c);
    endtask

    task automatic clear_model();
        hist.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) fb_m[r][c] = 3'b000;
    endtask

    // Monitor: every pulse pops one expectation and must arrive on its cycle.
    always @(negedge clk) begin
        if (rst_n && (row_valid || len_err || row_err)) begin
            int   k;
            exp_t e;
            checks++;
            k = row_valid ? K_VALID : (len_err ? K_LEN : K_ROW);
            if ((int'(row_valid) + int'(len_err) + int'(row_err)) != 1) begin
                errors++;
                $display("FAIL pulse_excl: valid=%b len=%b row=%b at cyc %0d", row_valid, len_err, row_err, cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: kind %0d at cyc %0d, none expected", k, cyc);
            end else begin
                e = exp_q.pop_front();
                if (k != e.kind || cyc != e.at ||
                    (k == K_VALID && (row_idx != 3'(e.idx) || row_red != e.r ||
                                      row_green != e.g || row_blue != e.b))) begin
                    errors++;
                    $display("FAIL pulse: got kind=%0d cyc=%0d idx=%0d r=%h g=%h b=%h expected kind=%0d cyc=%0d idx=%0d r=%h g=%h b=%h",
                             k, cyc, row_idx, row_red, row_green, row_blue,
                             e.kind, e.at, e.idx, e.r, e.g, e.b);
                end
            end
            checks++;
            if (frame_done !== (row_valid && row_idx == 3'd7)) begin
                errors++;
                $display("FAIL frame_done: got %b expected %b (idx %0d)", frame_done,
                         row_valid && row_idx == 3'd7, row_idx);
            end
        end else if (rst_n && frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done: got 1 expected 0 without row_valid at cyc %0d", cyc);
        end
    end

    initial begin
        logic [31:0] f;
        logic [7:0]  an;
        int          sel, len;

        bus.matrix_clk = 1'b0;
        bus.matrix_latch = 1'b0;
        bus.matrix_mosi = 1'b0;
        clear_model();

        // Reset with toggling inputs
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            bus.matrix_clk   = 1'($urandom);
            bus.matrix_latch = 1'($urandom);
            bus.matrix_mosi  = 1'($urandom);
        end
        bus.matrix_clk = 1'b0;
        bus.matrix_latch = 1'b0;
        bus.matrix_mosi = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(1);
        checks++;
        if ({row_valid, len_err, row_err, frame_done, row_idx, row_red, row_green, row_blue, rd_pixel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b len=%b row=%b done=%b idx=%0d r=%h g=%h b=%h pix=%b expected all 0",
                     row_valid, len_err, row_err, frame_done, row_idx, row_red, row_green, row_blue, rd_pixel);
        end
        read_all();

        // Good row 3, red column 0 only
        send_bits(build(8'h01, 8'h00, 8'h00, 8'h08), 0, 31);
        do_latch(0, 0);
        wait_cyc(4);
        read_check(3, 0);
        read_check(3, 1);

        // Short frame
        send_bits(build(8'hFF, 8'hFF, 8'hFF, 8'h01), 0, 30);
        do_latch(0, 0);
        wait_cyc(4);
        read_check(3, 0);
        read_check(1, 0);

        // Driver start-up pattern: all ones
        send_bits(32'hFFFF_FFFF, 0, 31);
        do_latch(0, 0);
        wait_cyc(4);
        read_check(3, 0);
        read_check(7, 7);

        // Reset mid-frame, then row 5 with green column 7
        send_bits(32'hFFFF_FFFF, 0, 15);
        rst_n = 1'b0;
        clear_model();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        send_bits(build(8'h00, 8'h80, 8'h00, 8'h20), 0, 31);
        do_latch(0, 0);
        wait_cyc(4);
        read_check(5, 7);
        read_check(3, 0);

        // Randomised frames: good, blank, multi-hot anode, bad length
        for (int i = 0; i < 14; i++) begin
            sel = $urandom_range(0, 5);
            an  = 8'(1 << $urandom_range(0, 7));
            if (sel == 3) an = 8'h00;
            if (sel == 4) an = an | 8'(1 << (($clog2(int'(an)) + $urandom_range(1, 7)) % 8));
            f = build(8'($urandom), 8'($urandom), 8'($urandom), an);
            len = 32;
            if (sel == 5) begin
                case ($urandom_range(0, 3))
                    0: len = 0;
                    1: len = 31;
                    2: len = 33;
                    default: len = 64;
                endcase
            end
            for (int k = 0; k < len; k++) shift_bit(f[k % 32]);
            do_latch(0, 0);
        end
        wait_cyc(4);
        read_all();

        // Full scan; row 7's latch coincides with the first shift of the next frame
        for (int r = 0; r < 8; r++) begin
            f = build(8'($urandom), 8'($urandom), 8'($urandom), 8'(1 << r));
            send_bits(f, 0, 31);
            if (r < 7) do_latch(0, 0);
        end
        f = build(8'($urandom), 8'($urandom), 8'($urandom), 8'h01);
        do_latch(1, f[0]);
        send_bits(f, 1, 31);
        do_latch(0, 0);
        wait_cyc(4);
        read_all();

        wait_cyc(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: %0d left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
